serial_bit_feeder: RTL and testbench

Upstream stage for the sequence detectors. It accepts parallel words over a valid/ready handshake, buffers up to two words, and serialises them one bit per enabled cycle onto a single-bit stream. That stream drives the detector's serial `in` input, with `clk` shared. Words stream back-to-back with no idle cycle between them whenever a buffered word is waiting.

---
 rtl/serial_bit_feeder_if.sv | 36 +++
 rtl/serial_bit_feeder.sv | 145 ++++++++++++++
 tb/tb_serial_bit_feeder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_if.sv
// Handshake and serial-stream signals between a word source, the bit feeder
// and the downstream sequence detector.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             bit_en;
    logic             bit_out;
    logic             bit_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output word_in,
        output word_valid,
        output bit_en,
        input  word_ready,
        input  bit_out,
        input  bit_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  word_in,
        input  word_valid,
        input  bit_en,
        output word_ready,
        output bit_out,
        output bit_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Two-deep word buffer feeding a shift register that emits one bit per enabled
// cycle, chaining buffered words back-to-back with no idle gap.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    serial_bit_feeder_if.slave bus
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic             last_bit;
    logic             load;
    logic             advance;
    logic             serial_bit;
    logic             serial_valid;
    logic             ready_int;

    // Ready is held low during reset so nothing is accepted while rst is 0.
    assign ready_int = rst && (count != 2'd2);
    assign push      = bus.word_valid && ready_int;
    assign pop       = load;
    assign last_bit  = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_en && last_bit && (count == 2'd0)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A pop on the last enabled bit reloads the shifter so the next word follows with no gap.
    always_comb begin
        load         = 1'b0;
        advance      = 1'b0;
        serial_bit   = 1'b0;
        serial_valid = 1'b0;
        case (state)
            IDLE: begin
                load = (count != 2'd0);
            end
            SHIFT: begin
                serial_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                serial_valid = bus.bit_en;
                if (bus.bit_en) begin
                    if (last_bit) begin
                        load = (count != 2'd0);
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= fifo_mem[rd_ptr];
            idx   <= '0;
        end else if (advance) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            idx <= idx + IDX_W'(1);
        end
    end

    assign bus.word_ready = ready_int;
    assign bus.bit_out    = serial_bit;
    assign bus.bit_valid  = serial_valid;
    assign bus.word_done  = serial_valid && last_bit;
    assign bus.busy       = rst && ((state == SHIFT) || (count != 2'd0));

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: reset, single word, back-to-back words,
// paced output, LSB-first ordering and reset in the middle of a word.
module tb_serial_bit_feeder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    serial_bit_feeder_if #(.WIDTH(WIDTH)) msb_if ();
    serial_bit_feeder_if #(.WIDTH(WIDTH)) lsb_if ();

    serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (msb_if.slave)
    );

    serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (lsb_if.slave)
    );

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] word, input logic en);
        msb_if.word_valid = valid;
        msb_if.word_in    = word;
        msb_if.bit_en     = en;
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Pushes one word into an empty block and steps through the IDLE pop cycle.
    task automatic loadWord(input logic [WIDTH-1:0] word);
        applyStimulus(1'b1, word, 1'b0);
        checkOutput("ready_before_push", 32'(msb_if.word_ready), 32'd1);
        waitCycle();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("busy_while_buffered", 32'(msb_if.busy), 32'd1);
        checkOutput("no_bit_in_idle", 32'(msb_if.bit_valid), 32'd0);
        waitCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  expWord;
        logic [7:0]  expLsb;
        logic [23:0] expStream;
        logic [7:0]  srcWords [3];
        int srcIdx, gotBits, doneCount, gapSeen, firstLow, firstHigh, validSeen;
        logic accepted;

        lsb_if.word_valid = 1'b0;
        lsb_if.word_in    = '0;
        lsb_if.bit_en     = 1'b0;

        // Reset held with a word offered
        rst = 1'b0;
        applyStimulus(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitCycle();
            checkOutput("rst_ready", 32'(msb_if.word_ready), 32'd0);
            checkOutput("rst_bit_valid", 32'(msb_if.bit_valid), 32'd0);
            checkOutput("rst_busy", 32'(msb_if.busy), 32'd0);
            checkOutput("rst_word_done", 32'(msb_if.word_done), 32'd0);
            checkOutput("rst_bit_out", 32'(msb_if.bit_out), 32'd0);
        end
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        waitCycle();
        checkOutput("ready_after_release", 32'(msb_if.word_ready), 32'd1);
        checkOutput("nothing_accepted", 32'(msb_if.busy), 32'd0);

        // Single word MSB-first
        expWord = 8'hD6;
        loadWord(expWord);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("single_valid", 32'(msb_if.bit_valid), 32'd1);
            checkOutput("single_bit", 32'(msb_if.bit_out), 32'(expWord[7-i]));
            checkOutput("single_done", 32'(msb_if.word_done), 32'(i == 7));
            waitCycle();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_idle_busy", 32'(msb_if.busy), 32'd0);
        checkOutput("single_idle_valid", 32'(msb_if.bit_valid), 32'd0);

        // Three words back-to-back
        expStream   = 24'hD60DB0;
        srcWords[0] = 8'hD6;
        srcWords[1] = 8'h0D;
        srcWords[2] = 8'hB0;
        srcIdx = 0; gotBits = 0; doneCount = 0; gapSeen = 0; firstLow = -1; firstHigh = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            applyStimulus(srcIdx < 3, srcWords[(srcIdx < 3) ? srcIdx : 0], 1'b1);
            if (msb_if.bit_valid) begin
                if (gotBits < 24) begin
                    checkOutput("stream_bit", 32'(msb_if.bit_out), 32'(expStream[23-gotBits]));
                end
                gotBits++;
            end else if (gotBits > 0 && gotBits < 24) begin
                gapSeen = 1;
            end
            if (msb_if.word_done) doneCount++;
            if (!msb_if.word_ready && firstLow < 0) firstLow = cyc;
            if (msb_if.word_ready && firstLow >= 0 && firstHigh < 0) firstHigh = cyc;
            accepted = msb_if.word_valid && msb_if.word_ready;
            waitCycle();
            if (accepted) srcIdx++;
        end
        checkOutput("stream_bits", 32'(gotBits), 32'd24);
        checkOutput("stream_gap", 32'(gapSeen), 32'd0);
        checkOutput("stream_done_pulses", 32'(doneCount), 32'd3);
        checkOutput("ready_drop_cycle", 32'(firstLow), 32'd3);
        checkOutput("ready_return_cycle", 32'(firstHigh), 32'd10);
        checkOutput("stream_end_busy", 32'(msb_if.busy), 32'd0);

        // Paced output with bit_en alternating
        loadWord(expWord);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, (i % 2) == 0);
            if ((i % 2) == 0) begin
                checkOutput("pace_valid", 32'(msb_if.bit_valid), 32'd1);
                checkOutput("pace_bit", 32'(msb_if.bit_out), 32'(expWord[7-i/2]));
                checkOutput("pace_done", 32'(msb_if.word_done), 32'(i == 14));
            end else begin
                checkOutput("pace_hold_valid", 32'(msb_if.bit_valid), 32'd0);
                checkOutput("pace_hold_done", 32'(msb_if.word_done), 32'd0);
                if (i < 15) begin
                    checkOutput("pace_hold_bit", 32'(msb_if.bit_out), 32'(expWord[7-(i+1)/2]));
                end
            end
            waitCycle();
        end
        checkOutput("pace_end_busy", 32'(msb_if.busy), 32'd0);

        // LSB-first instance
        expLsb = 8'b1101_0110;
        lsb_if.word_valid = 1'b1;
        lsb_if.word_in    = 8'h6B;
        #1;
        waitCycle();
        lsb_if.word_valid = 1'b0;
        waitCycle();
        for (int i = 0; i < 8; i++) begin
            lsb_if.bit_en = 1'b1;
            #1;
            checkOutput("lsb_valid", 32'(lsb_if.bit_valid), 32'd1);
            checkOutput("lsb_bit", 32'(lsb_if.bit_out), 32'(expLsb[7-i]));
            checkOutput("lsb_done", 32'(lsb_if.word_done), 32'(i == 7));
            waitCycle();
        end
        lsb_if.bit_en = 1'b0;
        #1;
        checkOutput("lsb_end_busy", 32'(lsb_if.busy), 32'd0);

        // Reset after three bits with a second word buffered
        applyStimulus(1'b1, 8'hD6, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 8'h0D, 1'b0);
        waitCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("midrst_bit", 32'(msb_if.bit_out), 32'(expWord[7-i]));
            waitCycle();
        end
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        waitCycle();
        checkOutput("midrst_valid", 32'(msb_if.bit_valid), 32'd0);
        checkOutput("midrst_busy", 32'(msb_if.busy), 32'd0);
        checkOutput("midrst_ready", 32'(msb_if.word_ready), 32'd0);
        rst = 1'b1;
        waitCycle();
        checkOutput("midrst_ready_back", 32'(msb_if.word_ready), 32'd1);
        validSeen = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (msb_if.bit_valid) validSeen++;
            waitCycle();
        end
        checkOutput("midrst_no_bits", 32'(validSeen), 32'd0);
        checkOutput("midrst_end_busy", 32'(msb_if.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
